// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Holds the ownership FSM encoding, the default NOP word and the address check used by both ports.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // RISC-V addi x0,x0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // A byte address is usable only if it is word aligned and falls inside the memory.
    function automatic logic addr_ok(input logic [63:0] byte_addr, input logic [63:0] byte_limit);
        return (byte_addr[1:0] == 2'b00) && (byte_addr < byte_limit);
    endfunction

endpackage

// File: rtl/imem_fetch_reg.sv
// Registered fetch output: one-cycle latency, stall hold, NOP substitution and sticky fault.
// Only captures while the fetch port owns memory; otherwise if_valid drops.
module imem_fetch_reg
    import imem_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  req,
    input  logic                  stall,
    input  logic                  addr_good,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  fault
);

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] instr_d, instr_q;
    logic                  fault_d, fault_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (!en) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = req;
            if (req) begin
                instr_d = addr_good ? rdata : NOP_INSTR;
                fault_d = fault_q | ~addr_good;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign fault = fault_q;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between the CPU fetch stage and the program loader.
// The loader owns memory in BOOT; a reload passes through one DRAIN cycle to finish an in-flight fetch.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_stall,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic                  if_fault,
    output logic                  cpu_hold,
    input  logic                  ld_req,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    input  logic                  ld_done,
    output logic                  ld_err,
    output logic [ADDR_WIDTH-1:0] ld_count,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'd4;

    arb_state_e            state_d, state_q;
    logic [ADDR_WIDTH-1:0] ld_count_d, ld_count_q;
    logic                  ld_err_d, ld_err_q;
    logic                  ld_addr_good, if_addr_good, ld_accept;

    assign ld_addr_good = addr_ok(64'(ld_addr), BYTE_LIMIT);
    assign if_addr_good = addr_ok(64'(if_addr), BYTE_LIMIT);

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        ld_err_d   = ld_err_q;
        ld_ready   = (state_q == ST_BOOT);
        cpu_hold   = (state_q != ST_RUN);
        ld_accept  = ld_valid & ld_ready;
        mem_addr   = if_addr >> 2;
        mem_wdata  = ld_data;
        mem_we     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                mem_addr = ld_addr >> 2;
                // A beat arriving with reset asserted is dropped along with the session.
                mem_we   = ld_accept & ld_addr_good & ~rst;
                if (ld_accept) begin
                    if (ld_addr_good) ld_count_d = ld_count_q + 1'b1;
                    else              ld_err_d   = 1'b1;
                end
                if (ld_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ld_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d    = ST_BOOT;
                ld_count_d = '0;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            ld_count_q <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign ld_count = ld_count_q;
    assign ld_err   = ld_err_q;

    imem_fetch_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_fetch_reg (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == ST_RUN),
        .req       (if_req),
        .stall     (if_stall),
        .addr_good (if_addr_good),
        .rdata     (mem_rdata),
        .valid     (if_valid),
        .instr     (if_instr),
        .fault     (if_fault)
    );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural single-port memory.
module tb_imem_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_stall, if_valid, if_fault, cpu_hold;
    logic [31:0] if_addr, if_instr;
    logic        ld_req, ld_valid, ld_ready, ld_done, ld_err;
    logic [31:0] ld_addr, ld_data, ld_count;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'hDEAD_BEEF;

    imem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_fault  (if_fault),
        .cpu_hold  (cpu_hold),
        .ld_req    (ld_req),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .ld_err    (ld_err),
        .ld_count  (ld_count),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One loader beat: checks the combinational memory port, then clocks it in.
    task automatic ld_beat(input logic [31:0] a, input logic [31:0] d, input logic done,
                           input logic exp_we, input logic [31:0] exp_maddr);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = done;
        #1;
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            check("mem_addr", mem_addr, exp_maddr);
            check("mem_wdata", mem_wdata, d);
        end
        tick();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_instr, input logic exp_fault);
        if_req  = 1'b1;
        if_addr = a;
        tick();
        check("fetch_valid", 32'(if_valid), 32'd1);
        check("fetch_instr", if_instr, exp_instr);
        check("fetch_fault", 32'(if_fault), 32'(exp_fault));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_stall = 1'b0;
        ld_req = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_fault", 32'(if_fault), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_ld_count", ld_count, 32'd0);

        // Boot load; ld_req during BOOT has no effect.
        ld_req = 1'b1;
        ld_beat(32'h0, 32'h0050_0093, 1'b0, 1'b1, 32'd0);
        ld_beat(32'h4, 32'h0010_0113, 1'b0, 1'b1, 32'd1);
        ld_beat(32'h8, 32'h0020_81B3, 1'b0, 1'b1, 32'd2);
        ld_req = 1'b0;
        check("load3_count", ld_count, 32'd3);
        check("load3_hold", 32'(cpu_hold), 32'd1);

        // Misaligned beat is dropped and flagged.
        ld_beat(32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        check("bad_ld_err", 32'(ld_err), 32'd1);
        check("bad_ld_count", ld_count, 32'd3);

        // Last beat coincides with ld_done: written, then RUN.
        ld_valid = 1'b1; ld_addr = 32'hC; ld_data = 32'h0030_8233; ld_done = 1'b1;
        #1;
        check("done_beat_we", 32'(mem_we), 32'd1);
        check("done_beat_maddr", mem_addr, 32'd3);
        check("done_beat_hold", 32'(cpu_hold), 32'd1);
        tick();
        ld_valid = 1'b0; ld_done = 1'b0;
        check("run_count", ld_count, 32'd4);
        check("run_hold", 32'(cpu_hold), 32'd0);
        check("run_ld_ready", 32'(ld_ready), 32'd0);

        // Loader activity in RUN is ignored.
        ld_valid = 1'b1; ld_addr = 32'h10; ld_done = 1'b1;
        #1;
        check("run_ld_we", 32'(mem_we), 32'd0);
        tick();
        ld_valid = 1'b0; ld_done = 1'b0;
        check("run_ld_count", ld_count, 32'd4);
        check("run_done_ignored", 32'(cpu_hold), 32'd0);

        // Fetch then stall with changing address and request.
        fetch(32'h4, 32'h0010_0113, 1'b0);
        if_stall = 1'b1;
        if_addr = 32'h8; tick();
        check("stall1_valid", 32'(if_valid), 32'd1);
        check("stall1_instr", if_instr, 32'h0010_0113);
        if_addr = 32'h0; if_req = 1'b0; tick();
        check("stall2_instr", if_instr, 32'h0010_0113);
        if_addr = 32'h1000; if_req = 1'b1; tick();
        check("stall3_valid", 32'(if_valid), 32'd1);
        check("stall3_instr", if_instr, 32'h0010_0113);
        check("stall3_fault", 32'(if_fault), 32'd0);
        if_stall = 1'b0; if_req = 1'b0;
        tick();
        check("idle_valid", 32'(if_valid), 32'd0);

        fetch(32'h8, 32'h0020_81B3, 1'b0);
        fetch(32'h1000, NOP, 1'b1);
        fetch(32'h6, NOP, 1'b1);
        fetch(32'h0, 32'h0050_0093, 1'b1);

        // Reload during an active fetch: result delivered in DRAIN, then BOOT.
        if_addr = 32'hC; ld_req = 1'b1;
        tick();
        check("drain_valid", 32'(if_valid), 32'd1);
        check("drain_instr", if_instr, 32'h0030_8233);
        check("drain_hold", 32'(cpu_hold), 32'd1);
        check("drain_ld_ready", 32'(ld_ready), 32'd0);
        ld_req = 1'b0; if_addr = 32'h0;
        tick();
        check("reboot_valid", 32'(if_valid), 32'd0);
        check("reboot_hold", 32'(cpu_hold), 32'd1);
        check("reboot_ld_ready", 32'(ld_ready), 32'd1);
        check("reboot_count", ld_count, 32'd0);
        if_req = 1'b0;
        tick();
        check("boot_valid_low", 32'(if_valid), 32'd0);

        // Reset in the middle of a second load session.
        ld_beat(32'h20, 32'h1111_1111, 1'b0, 1'b1, 32'd8);
        ld_beat(32'h24, 32'h2222_2222, 1'b0, 1'b1, 32'd9);
        check("mid_count", ld_count, 32'd2);
        rst = 1'b1; ld_valid = 1'b1; ld_addr = 32'h28; ld_data = 32'h3333_3333;
        #1;
        check("rst_beat_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        check("rst2_count", ld_count, 32'd0);
        check("rst2_ld_err", 32'(ld_err), 32'd0);
        check("rst2_if_fault", 32'(if_fault), 32'd0);
        check("rst2_hold", 32'(cpu_hold), 32'd1);
        check("rst2_if_instr", if_instr, NOP);
        check("rst2_mem_untouched", mem[10], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
